// File: rtl/sorter_pkg.sv
// Shared definitions for the sequential odd-even transposition sorter.
// State encoding and the index-width helper.
package sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Signed compare-exchange cell; swaps only on strict inequality.
// Equal inputs always pass straight through.
module cmp_swap #(
    parameter int N       = 8,
    parameter int DESCEND = 0
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] lo_first,
    output logic signed [N-1:0] hi_second
);

    logic swap;

    assign swap      = (DESCEND != 0) ? (a < b) : (a > b);
    assign lo_first  = swap ? b : a;
    assign hi_second = swap ? a : b;

endmodule

// File: rtl/bubble_sorter_seq.sv
// Frame sorter: load DEPTH elements, run DEPTH odd-even phases,
// then stream the sorted frame out with valid/ready.
module bubble_sorter_seq #(
    parameter int N       = 8,
    parameter int DEPTH   = 8,
    parameter int DESCEND = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_data,
    output logic                out_last,
    output logic                busy
);

    import sorter_pkg::*;

    localparam int IW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    state_t state;
    state_t state_nx;

    logic [DEPTH-1:0][N-1:0] elems;
    logic [DEPTH-1:0][N-1:0] ev;
    logic [DEPTH-1:0][N-1:0] od;

    logic [IW-1:0] load_idx;
    logic [IW-1:0] phase;
    logic [IW-1:0] drain_idx;

    logic take;
    logic give;
    logic load_done;
    logic sort_done;

    // Even phase: pairs (0,1),(2,3)...
    genvar k;
    generate
        for (k = 0; k < DEPTH / 2; k++) begin : gen_ev
            cmp_swap #(.N(N), .DESCEND(DESCEND)) u_cs (
                .a        (elems[2*k]),
                .b        (elems[2*k+1]),
                .lo_first (ev[2*k]),
                .hi_second(ev[2*k+1])
            );
        end
        if (DEPTH % 2 == 1) begin : gen_ev_tail
            assign ev[DEPTH-1] = elems[DEPTH-1];
        end
    endgenerate

    // Odd phase: pairs (1,2),(3,4)...; element 0 passes through
    assign od[0] = elems[0];
    generate
        for (k = 0; k < (DEPTH - 1) / 2; k++) begin : gen_od
            cmp_swap #(.N(N), .DESCEND(DESCEND)) u_cs (
                .a        (elems[2*k+1]),
                .b        (elems[2*k+2]),
                .lo_first (od[2*k+1]),
                .hi_second(od[2*k+2])
            );
        end
        if (DEPTH % 2 == 0) begin : gen_od_tail
            assign od[DEPTH-1] = elems[DEPTH-1];
        end
    endgenerate

    assign take      = in_valid & in_ready;
    assign give      = out_valid & out_ready;
    assign load_done = take && (load_idx == LAST);
    assign sort_done = (state == SORT) && (phase == LAST);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (load_done) state_nx = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) state_nx = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = elems[drain_idx];
                out_last  = (drain_idx == LAST);
                if (out_ready && out_last) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            load_idx  <= '0;
            phase     <= '0;
            drain_idx <= '0;
            elems     <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                LOAD: begin
                    phase <= '0;
                    if (take) begin
                        elems[load_idx] <= in_data;
                        load_idx <= load_done ? '0 : load_idx + 1'b1;
                    end
                end
                SORT: begin
                    elems     <= phase[0] ? od : ev;
                    phase     <= sort_done ? '0 : phase + 1'b1;
                    drain_idx <= '0;
                end
                DRAIN: begin
                    load_idx <= '0;
                    if (give) begin
                        drain_idx <= out_last ? '0 : drain_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sorter_seq.sv
// Directed bench for bubble_sorter_seq: ascending/descending DEPTH=4,
// stalls, reset mid-sort, back-to-back frames and a DEPTH=8 worst case.
module tb_bubble_sorter_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic              vld [3];
    logic              rdy [3];
    logic              ir  [3];
    logic              ov  [3];
    logic              ol  [3];
    logic              by  [3];
    logic signed [7:0] din [3];
    logic signed [7:0] od  [3];

    int checks = 0;
    int errors = 0;

    bubble_sorter_seq #(.N(8), .DEPTH(4), .DESCEND(0)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[0]), .in_ready(ir[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
        .out_last(ol[0]), .busy(by[0])
    );

    bubble_sorter_seq #(.N(8), .DEPTH(4), .DESCEND(1)) u_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[1]), .in_ready(ir[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
        .out_last(ol[1]), .busy(by[1])
    );

    bubble_sorter_seq #(.N(8), .DEPTH(8), .DESCEND(0)) u_d8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[2]), .in_ready(ir[2]), .in_data(din[2]),
        .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od[2]),
        .out_last(ol[2]), .busy(by[2])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int d, input int v [8], input int n);
        chk("ld_rdy", int'(ir[d]), 1);
        for (int i = 0; i < n; i++) begin
            din[d] = 8'(v[i]);
            vld[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        vld[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input int exp_lat);
        int n;
        n = 0;
        while (!ov[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat", n, exp_lat);
    endtask

    task automatic drain(input int d, input int e [8],
                         input int from, input int to, input int n);
        rdy[d] = 1'b1;
        for (int i = from; i < to; i++) begin
            chk("ov", int'(ov[d]), 1);
            chk("data", int'(od[d]), e[i]);
            chk("last", int'(ol[d]), int'(i == n - 1));
            chk("ir_drain", int'(ir[d]), 0);
            @(posedge clk);
            #1;
        end
        rdy[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycles %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lc [2];
        int k;
        logic signed [7:0] held;

        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            rdy[i] = 1'b0;
            din[i] = '0;
        end

        // reset values
        #12;
        chk("rst_ir", int'(ir[0]), 1);
        chk("rst_ov", int'(ov[0]), 0);
        chk("rst_ol", int'(ol[0]), 0);
        chk("rst_busy", int'(by[0]), 0);
        chk("rst_data", int'(od[0]), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ascending basic frame
        load(0, '{3, -1, 7, 0, 0, 0, 0, 0}, 4);
        chk("sort_busy", int'(by[0]), 1);
        chk("sort_ir", int'(ir[0]), 0);
        chk("sort_ov", int'(ov[0]), 0);
        wait_out(0, 4);
        drain(0, '{-1, 0, 3, 7, 0, 0, 0, 0}, 0, 4, 4);
        chk("post_ir", int'(ir[0]), 1);
        chk("post_busy", int'(by[0]), 0);
        chk("post_ov", int'(ov[0]), 0);

        // descending with duplicates and extremes
        load(1, '{5, 5, -128, 127, 0, 0, 0, 0}, 4);
        wait_out(1, 4);
        drain(1, '{127, 5, 5, -128, 0, 0, 0, 0}, 0, 4, 4);

        // stall mid-drain
        load(0, '{10, -5, 0, 2, 0, 0, 0, 0}, 4);
        wait_out(0, 4);
        drain(0, '{-5, 0, 2, 10, 0, 0, 0, 0}, 0, 1, 4);
        held = od[0];
        chk("stall_first", int'(held), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_ov", int'(ov[0]), 1);
            chk("stall_data", int'(od[0]), int'(held));
            chk("stall_last", int'(ol[0]), 0);
        end
        drain(0, '{-5, 0, 2, 10, 0, 0, 0, 0}, 1, 4, 4);

        // reset during SORT cycle 2
        load(0, '{9, 8, 7, 6, 0, 0, 0, 0}, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", int'(ov[0]), 0);
        chk("arst_ir", int'(ir[0]), 1);
        chk("arst_busy", int'(by[0]), 0);
        chk("arst_data", int'(od[0]), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_stale", int'(ov[0]), 0);
        load(0, '{4, 3, 2, 1, 0, 0, 0, 0}, 4);
        wait_out(0, 4);
        drain(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 0, 4, 4);

        // back-to-back frames, continuous valid/ready
        lc[0] = 0;
        lc[1] = 0;
        k = 0;
        rdy[0] = 1'b1;
        fork
            begin
                int sv [8];
                logic acc;
                int n;
                sv = '{4, 1, 3, 2, -1, -3, -2, -4};
                for (int i = 0; i < 8; i++) begin
                    din[0] = 8'(sv[i]);
                    vld[0] = 1'b1;
                    n = 0;
                    do begin
                        acc = ir[0];
                        @(posedge clk);
                        #1;
                        n++;
                    end while (!acc && n < 100);
                end
                vld[0] = 1'b0;
            end
            begin
                int ex [8];
                int n;
                ex = '{1, 2, 3, 4, -4, -3, -2, -1};
                for (int j = 0; j < 8; j++) begin
                    n = 0;
                    while (!ov[0] && n < 100) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (n >= 100) chk("b2b_tmo", n, 0);
                    chk("b2b_data", int'(od[0]), ex[j]);
                    chk("b2b_last", int'(ol[0]), int'(j == 3 || j == 7));
                    if (ol[0] && k < 2) begin
                        chk("b2b_ir_last", int'(ir[0]), 0);
                        lc[k] = cyc;
                        k++;
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        rdy[0] = 1'b0;
        chk("b2b_period", lc[1] - lc[0], 12);

        // DEPTH=8 worst case
        load(2, '{7, 6, 5, 4, 3, 2, 1, 0}, 8);
        wait_out(2, 8);
        drain(2, '{0, 1, 2, 3, 4, 5, 6, 7}, 0, 8, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
